// File: rtl/left_shift_pkg.sv
// Shared definitions for the pipelined left shifter: shift-amount width helper
// and the per-stage record layout at the default data width.
package left_shift_pkg;

    // Number of shift-amount bits (and pipeline stages) for a given data width.
    function automatic int shw_of(input int width);
        return $clog2(width);
    endfunction

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SHW   = shw_of(DEF_WIDTH);

    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] data;
        logic [DEF_SHW-1:0]   shamt;
        logic                 rot;
    } stage_t;

endpackage

// File: rtl/shl_stage.sv
// One pipeline slice of the left shifter: a registered 2:1 mux row that shifts
// (or rotates) by DIST when its shift-amount bit is set, with a valid/ready slot.
module shl_stage
    import left_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIST  = 1,
    localparam int SHW  = shw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic [SHW-1:0]   up_shamt,
    input  logic             up_rot,
    output logic             up_ready,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    output logic [SHW-1:0]   dn_shamt,
    output logic             dn_rot,
    input  logic             dn_ready
);

    localparam int BIT = $clog2(DIST);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   shamt;
        logic             rot;
    } slot_t;

    slot_t            slot_r;
    logic [WIDTH-1:0] shifted_s;
    logic             load_s;

    // The slot may load whenever it is empty or its content moves on this cycle.
    assign load_s   = ~slot_r.valid | dn_ready;
    assign up_ready = load_s;

    // Mux row: shift by DIST when this stage's amount bit is set.
    always_comb begin
        shifted_s = up_data;
        if (up_shamt[BIT]) begin
            if (up_rot) begin
                shifted_s = (up_data << DIST) | (up_data >> (WIDTH - DIST));
            end else begin
                shifted_s = up_data << DIST;
            end
        end else begin
            shifted_s = up_data;
        end
    end

    // Slot register: load from upstream when allowed, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r.valid <= 1'b0;
            slot_r.data  <= {WIDTH{1'b0}};
            slot_r.shamt <= {SHW{1'b0}};
            slot_r.rot   <= 1'b0;
        end else if (load_s) begin
            slot_r.valid <= up_valid;
            slot_r.data  <= shifted_s;
            slot_r.shamt <= up_shamt;
            slot_r.rot   <= up_rot;
        end else begin
            slot_r <= slot_r;
        end
    end

    assign dn_valid = slot_r.valid;
    assign dn_data  = slot_r.data;
    assign dn_shamt = slot_r.shamt;
    assign dn_rot   = slot_r.rot;

endmodule

// File: rtl/left_shift_pipe.sv
// Pipelined left barrel shifter: SHW registered stages, largest shift first.
// Define LEFT_SHIFT_PIPE_ROTATE_EN to add the in_rot port (rotate instead of zero fill).
module left_shift_pipe
    import left_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SHW  = shw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
`ifdef LEFT_SHIFT_PIPE_ROTATE_EN
    input  logic             in_rot,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_s [0:SHW];
    logic             ready_s [0:SHW];
    logic [WIDTH-1:0] data_s  [0:SHW];
    logic [SHW-1:0]   shamt_s [0:SHW];
    logic             rot_s   [0:SHW];
    logic             unused_tail_s;

    assign valid_s[0]   = in_valid;
    assign data_s[0]    = in_data;
    assign shamt_s[0]   = in_shamt;
`ifdef LEFT_SHIFT_PIPE_ROTATE_EN
    assign rot_s[0]     = in_rot;
`else
    assign rot_s[0]     = 1'b0;
`endif
    assign ready_s[SHW] = out_ready;
    assign in_ready     = ready_s[0];

    // Stage k handles amount bit SHW-1-k, so the widest shift comes first.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shl_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << (SHW - 1 - k))
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (valid_s[k]),
            .up_data  (data_s[k]),
            .up_shamt (shamt_s[k]),
            .up_rot   (rot_s[k]),
            .up_ready (ready_s[k]),
            .dn_valid (valid_s[k+1]),
            .dn_data  (data_s[k+1]),
            .dn_shamt (shamt_s[k+1]),
            .dn_rot   (rot_s[k+1]),
            .dn_ready (ready_s[k+1])
        );
    end

    assign out_valid     = valid_s[SHW];
    assign out_data      = data_s[SHW];
    assign unused_tail_s = ^{shamt_s[SHW], rot_s[SHW]};

endmodule

// File: tb/tb_left_shift_pipe.sv
// Directed bench for left_shift_pipe with a queue-based reference model.
module tb_left_shift_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_shamt = 3'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    bit         rot_sel = 1'b0;

    left_shift_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
`ifdef LEFT_SHIFT_PIPE_ROTATE_EN
        .in_rot    (rot_sel),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t       q[$];
    logic [7:0] got[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cnt = 0;
    int         out_cnt = 0;
    bit         started = 1'b0;
    bit         check_lat = 1'b0;
    bit         prev_stall = 1'b0;
    bit         prev_rst = 1'b1;
    logic [7:0] prev_data = 8'h00;

    // Reference: shift (or rotate) as 8-bit arithmetic.
    function automatic logic [7:0] model(input logic [7:0] d, input int s, input bit r);
        logic [15:0] w;
        logic [7:0]  t;
        w = {d, d} << s;
        t = d << s;
        return r ? w[15:8] : t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: every cycle, check handshake and outputs against the model.
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            chk("in_ready", in_ready, ((q.size() < 3) || out_ready) ? 1 : 0);
            chk("no_stale", (out_valid && q.size() == 0) ? 1 : 0, 0);
            if (prev_stall && !prev_rst) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("out_data", out_data, e.d);
                if (check_lat) chk("latency", cyc - e.c, 3);
                got.push_back(out_data);
                out_cnt++;
            end
            if (rst) begin
                q.delete();
            end else if (in_valid && in_ready) begin
                q.push_back('{model(in_data, int'(in_shamt), rot_sel), cyc});
                acc_cnt++;
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_rst   = rst;
        prev_data  = out_data;
    end

    task automatic send(input logic [7:0] d, input logic [2:0] s, input bit r);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        rot_sel  = r;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_timeout actual=no_accept required=accept");
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int a0;
    int o0;

    initial begin
        @(posedge clk);
        #1;
        started = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // 1: single operand, exact latency
        out_ready = 1'b1;
        check_lat = 1'b1;
        got.delete();
        send(8'h81, 3'd3, 1'b0);
        idle(6);
        chk("t1_count", got.size(), 1);
        if (got.size() > 0) chk("t1_data", got[0], 8'h08);

        // 2: back-to-back stream
        got.delete();
        send(8'hFF, 3'd0, 1'b0);
        send(8'hFF, 3'd7, 1'b0);
        send(8'h5A, 3'd1, 1'b0);
        send(8'h01, 3'd4, 1'b0);
        idle(6);
        chk("t2_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("t2_r0", got[0], 8'hFF);
            chk("t2_r1", got[1], 8'h80);
            chk("t2_r2", got[2], 8'hB4);
            chk("t2_r3", got[3], 8'h10);
        end
        check_lat = 1'b0;

        // 3: backpressure
        out_ready = 1'b0;
        got.delete();
        a0 = acc_cnt;
        fork
            begin
                send(8'h11, 3'd1, 1'b0);
                send(8'h0F, 3'd4, 1'b0);
                send(8'hC3, 3'd2, 1'b0);
                send(8'h80, 3'd0, 1'b0);
            end
            begin
                idle(8);
                chk("t3_accepted", acc_cnt - a0, 3);
                out_ready = 1'b1;
            end
        join
        idle(6);
        chk("t3_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("t3_r0", got[0], 8'h22);
            chk("t3_r1", got[1], 8'hF0);
            chk("t3_r2", got[2], 8'h0C);
            chk("t3_r3", got[3], 8'h80);
        end

        // 4: reset mid-flight
        out_ready = 1'b0;
        o0 = out_cnt;
        send(8'h01, 3'd1, 1'b0);
        send(8'h02, 3'd2, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t4_out_valid", out_valid, 0);
        chk("t4_out_data", out_data, 8'h00);
        chk("t4_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(6);
        chk("t4_no_output", out_cnt - o0, 0);

        // 5: continuous streaming at full rate
        check_lat = 1'b1;
        a0 = acc_cnt;
        o0 = out_cnt;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i * 37 + 5);
            in_shamt = 3'(i % 8);
            rot_sel  = 1'b0;
            idle(1);
        end
        in_valid = 1'b0;
        chk("t5_accepts", acc_cnt - a0, 20);
        idle(6);
        chk("t5_outputs", out_cnt - o0, 20);

`ifdef LEFT_SHIFT_PIPE_ROTATE_EN
        // 6: rotate vs shift
        got.delete();
        send(8'h81, 3'd1, 1'b1);
        send(8'h81, 3'd1, 1'b0);
        idle(6);
        chk("t6_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t6_rot", got[0], 8'h03);
            chk("t6_shl", got[1], 8'h02);
        end
`endif
        check_lat = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
